pipelined_shifter: RTL and testbench
====================================

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline register count; legal range 1 to log2(WIDTH).
REQ-003 SHALL have derived localparam SHW = log2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_amt  input  SHW  shift amount.
REQ-010 in_op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  WIDTH  result.
REQ-014 out_zero  output  1  out_data equals zero.
REQ-015 out_illegal  output  1  in_op was an undefined encoding.

Function
REQ-016 SHALL accept a request on a rising edge where in_valid and in_ready are both high.
REQ-017 SHALL present the result on out_valid exactly STAGES cycles after acceptance, provided no stall occurs.
REQ-018 SHALL implement the shift as SHW binary stages (by 1, 2, 4, ...), distributed as evenly as possible over STAGES registers, with the remainder assigned to the earliest registers.
REQ-019 SLL: zero-fill from the LSB; SRL: zero-fill from the MSB; SRA: replicate in_data[WIDTH-1].
REQ-020 ROL/ROR: rotate; bits leaving one end re-enter at the other end.
REQ-021 in_amt = 0: SHALL output in_data unchanged for every op.
REQ-022 Undefined in_op (101, 110, 111): SHALL output in_data unchanged, with out_illegal = 1 for that result.
REQ-023 out_zero and out_illegal SHALL be registered alongside out_data and be valid whenever out_valid is high.
REQ-024 Stall: while out_valid = 1 and out_ready = 0, the whole pipeline SHALL hold, and in_ready SHALL equal NOT (out_valid AND NOT out_ready).
REQ-025 SHALL hold out_data, out_zero and out_illegal stable while out_valid = 1 and out_ready = 0.
REQ-026 Throughput: SHALL sustain one accepted request per cycle while out_ready = 1, with no bubbles.
REQ-027 A stage holding no valid request SHALL still advance when unstalled, so bubbles collapse.
REQ-028 Simultaneous acceptance at the input and retirement at the output in one cycle SHALL both take effect.
REQ-029 Results SHALL leave in acceptance order.

Reset
REQ-030 When rstn = 0: all stage valid bits SHALL be 0, and out_valid, out_data, out_zero and out_illegal SHALL be 0.
REQ-031 in_ready SHALL be 1 during reset and after reset is released.
REQ-032 Reset mid-operation SHALL discard all in-flight requests; no result for those requests appears after release.
REQ-033 The first acceptance SHALL be possible on the first rising edge with rstn = 1.

Structure
REQ-034 Package pipelined_shifter_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR) and the op type.
REQ-035 Sub-module shift_stage SHALL be combinational: one binary stage, parameterised by WIDTH and step, taking data, one amount bit and op, and producing shifted data.
REQ-036 The top level SHALL instantiate SHW shift_stage instances and STAGES register slices, each slice carrying data, remaining amount bits, op, illegal flag and valid.

Verification
REQ-037 WIDTH=32, STAGES=2: SRA 0x80000000 by 4 -> 0xF8000000 two cycles after acceptance, out_zero = 0.
REQ-038 ROR 0x00000001 by 1 -> 0x80000000; ROL 0x80000001 by 4 -> 0x00000018; SLL 0x00000001 by 31 -> 0x80000000.
REQ-039 SRL 0x00000010 by 5 -> 0x00000000 with out_zero = 1; in_op = 110 with in_data 0x1234ABCD -> 0x1234ABCD with out_illegal = 1.
REQ-040 Four back-to-back requests with out_ready = 1 -> four consecutive out_valid cycles, in order.
REQ-041 Hold out_ready = 0 for 3 cycles while streaming -> in_ready = 0, out_data frozen, no loss and no duplication after release.
REQ-042 Drop rstn for one cycle with 2 requests in flight -> out_valid = 0 immediately; no stale results after release.

Source files
------------

// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   op_t / OP_*   : operation encodings carried with each request
//   op_is_illegal : flags encodings with no defined operation
//   slice_count   : number of binary shift stages placed before register slice k
//   slice_first   : index of the first binary shift stage handled by slice k
package pipelined_shifter_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_ROL = 3'b011;
  localparam op_t OP_ROR = 3'b100;

  function automatic logic op_is_illegal(input op_t op);
    return (op > OP_ROR);
  endfunction

  // Stages are spread evenly; leftover stages go to the earliest slices.
  function automatic int unsigned slice_count(input int unsigned k, input int unsigned shw,
                                              input int unsigned stages);
    return (shw / stages) + ((k < (shw % stages)) ? 1 : 0);
  endfunction

  function automatic int unsigned slice_first(input int unsigned k, input int unsigned shw,
                                              input int unsigned stages);
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < k; i++) begin
      sum += slice_count(i, shw, stages);
    end
    return sum;
  endfunction

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// One combinational binary stage of the barrel shifter.
//   data_i    : operand entering this stage
//   amt_bit_i : shift-amount bit selecting a move of STEP positions
//   op_i      : operation; undefined encodings pass data through
//   data_o    : operand after this stage
module shift_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             amt_bit_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (amt_bit_i) begin
      case (op_i)
        OP_SLL:  data_o = data_i << STEP;
        OP_SRL:  data_o = data_i >> STEP;
        OP_SRA:  data_o = $signed(data_i) >>> STEP;
        OP_ROL:  data_o = (data_i << STEP) | (data_i >> (WIDTH - STEP));
        OP_ROR:  data_o = (data_i >> STEP) | (data_i << (WIDTH - STEP));
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready handshake on both sides.
//   clk, rstn              : clock, asynchronous active-low reset
//   in_valid/in_ready      : request handshake
//   in_data, in_amt, in_op : operand, shift amount, operation
//   out_valid/out_ready    : result handshake
//   out_data               : shifted result
//   out_zero               : out_data is all zeros
//   out_illegal            : request carried an undefined op (data passed through)
// SHW binary stages are split across STAGES register slices; the whole pipe
// advances together unless the output holds a result the consumer refuses.
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int unsigned  WIDTH  = 32,
  parameter int unsigned  STAGES = 2,
  localparam int unsigned SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_illegal
);

  // Register slice outputs, indexed by slice.
  logic [WIDTH-1:0] sl_data [STAGES];
  logic [SHW-1:0]   sl_amt  [STAGES];
  op_t              sl_op   [STAGES];
  logic             sl_ill  [STAGES];
  logic             sl_vld  [STAGES];
  // Combinational result feeding each slice register.
  logic [WIDTH-1:0] sl_next [STAGES];

  logic adv;
  logic out_zero_q;

  // Only a refused result stalls; empty slices still move so bubbles collapse.
  assign in_ready = ~(out_valid & ~out_ready);
  assign adv      = in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int unsigned Cnt   = slice_count(k, SHW, STAGES);
    localparam int unsigned First = slice_first(k, SHW, STAGES);

    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   a_in;
    op_t              o_in;
    logic             i_in;
    logic             v_in;

    if (k == 0) begin : g_src_in
      assign d_in = in_data;
      assign a_in = in_amt;
      assign o_in = in_op;
      assign i_in = op_is_illegal(in_op);
      assign v_in = in_valid;
    end else begin : g_src_prev
      assign d_in = sl_data[k-1];
      assign a_in = sl_amt[k-1];
      assign o_in = sl_op[k-1];
      assign i_in = sl_ill[k-1];
      assign v_in = sl_vld[k-1];
    end

    logic [WIDTH-1:0] chain [Cnt+1];
    assign chain[0] = d_in;

    for (genvar i = 0; i < Cnt; i++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .STEP  (1 << (First + i))
      ) u_stage (
        .data_i    (chain[i]),
        .amt_bit_i (a_in[First+i]),
        .op_i      (o_in),
        .data_o    (chain[i+1])
      );
    end

    assign sl_next[k] = chain[Cnt];

    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    op_t              op_q;
    logic             ill_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        data_q <= '0;
        amt_q  <= '0;
        op_q   <= OP_SLL;
        ill_q  <= 1'b0;
        vld_q  <= 1'b0;
      end else if (adv) begin
        data_q <= chain[Cnt];
        amt_q  <= a_in;
        op_q   <= o_in;
        ill_q  <= i_in;
        vld_q  <= v_in;
      end
    end

    assign sl_data[k] = data_q;
    assign sl_amt[k]  = amt_q;
    assign sl_op[k]   = op_q;
    assign sl_ill[k]  = ill_q;
    assign sl_vld[k]  = vld_q;

    // Already-consumed amount bits (and everything in the last slice) have no reader.
    logic unused_carry;
    assign unused_carry = ^{sl_amt[k], sl_op[k]};
  end

  // Zero flag is computed before the final register so it travels with out_data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_zero_q <= 1'b0;
    end else if (adv) begin
      out_zero_q <= (sl_next[STAGES-1] == '0);
    end
  end

  assign out_valid   = sl_vld[STAGES-1];
  assign out_data    = sl_data[STAGES-1];
  assign out_illegal = sl_ill[STAGES-1];
  assign out_zero    = out_zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter (WIDTH=32, STAGES=2).
module tb_pipelined_shifter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned SHW    = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_illegal;

  int checks = 0;
  int errors = 0;

  pipelined_shifter #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_amt      (in_amt),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic [2:0] op, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_op     = op;
    out_ready = ordy;
  endtask

  // One isolated request: result must appear exactly two cycles after acceptance.
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] a, input logic [31:0] exp, input logic z,
                        input logic ill);
    drive(1'b1, d, a, op, 1'b1);
    #1;
    chk_bit({tag, " in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_bit({tag, " early out_valid"}, out_valid, 1'b0);
    tick();
    chk_bit({tag, " out_valid"}, out_valid, 1'b1);
    chk({tag, " out_data"}, out_data, exp);
    chk_bit({tag, " out_zero"}, out_zero, z);
    chk_bit({tag, " out_illegal"}, out_illegal, ill);
    tick();
    chk_bit({tag, " retire"}, out_valid, 1'b0);
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_d;
  } row_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] exp;
  } req_t;

  row_t stall_tbl [9];
  req_t b2b_tbl [4];

  initial begin
    rstn = 1'b1;
    drive(1'b0, '0, '0, 3'b000, 1'b1);
    #2 rstn = 1'b0;
    #2;
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 32'h0);
    chk_bit("reset out_zero", out_zero, 1'b0);
    chk_bit("reset out_illegal", out_illegal, 1'b0);
    chk_bit("reset in_ready", in_ready, 1'b1);
    tick();
    chk_bit("reset held out_valid", out_valid, 1'b0);
    rstn = 1'b1;
    chk_bit("post-reset in_ready", in_ready, 1'b1);

    // Isolated requests, first one on the first edge after release.
    single("sra", 3'b010, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);
    single("ror", 3'b100, 32'h0000_0001, 5'd1, 32'h8000_0000, 1'b0, 1'b0);
    single("rol", 3'b011, 32'h8000_0001, 5'd4, 32'h0000_0018, 1'b0, 1'b0);
    single("sll31", 3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    single("srl zero", 3'b001, 32'h0000_0010, 5'd5, 32'h0000_0000, 1'b1, 1'b0);
    single("illegal110", 3'b110, 32'h1234_ABCD, 5'd7, 32'h1234_ABCD, 1'b0, 1'b1);
    single("illegal111", 3'b111, 32'h0000_0000, 5'd3, 32'h0000_0000, 1'b1, 1'b1);
    single("sra31 pos", 3'b010, 32'h4000_0000, 5'd31, 32'h0000_0000, 1'b1, 1'b0);
    single("rol amt0", 3'b011, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    single("srl16", 3'b001, 32'hABCD_1234, 5'd16, 32'h0000_ABCD, 1'b0, 1'b0);

    // Four back-to-back requests, consumer always ready.
    b2b_tbl[0] = '{op: 3'b001, d: 32'hF000_0000, a: 5'd4,  exp: 32'h0F00_0000};
    b2b_tbl[1] = '{op: 3'b100, d: 32'h1234_5678, a: 5'd16, exp: 32'h5678_1234};
    b2b_tbl[2] = '{op: 3'b010, d: 32'h8000_0000, a: 5'd0,  exp: 32'h8000_0000};
    b2b_tbl[3] = '{op: 3'b011, d: 32'h0000_000F, a: 5'd30, exp: 32'hC000_0003};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, b2b_tbl[i].d, b2b_tbl[i].a, b2b_tbl[i].op, 1'b1);
      else       drive(1'b0, '0, '0, 3'b000, 1'b1);
      tick();
      if (i >= 1 && i <= 4) begin
        chk_bit($sformatf("b2b out_valid %0d", i), out_valid, 1'b1);
        chk($sformatf("b2b out_data %0d", i), out_data, b2b_tbl[i-1].exp);
      end else begin
        chk_bit($sformatf("b2b out_valid %0d", i), out_valid, 1'b0);
      end
    end

    // Streaming with a three-cycle consumer stall; source holds its request while refused.
    stall_tbl[0] = '{v: 1, d: 32'hA1, ordy: 1, exp_ir: 1, exp_ov: 0, exp_d: 32'h0};
    stall_tbl[1] = '{v: 1, d: 32'hA2, ordy: 1, exp_ir: 1, exp_ov: 1, exp_d: 32'hA10};
    stall_tbl[2] = '{v: 1, d: 32'hA3, ordy: 0, exp_ir: 0, exp_ov: 1, exp_d: 32'hA10};
    stall_tbl[3] = '{v: 1, d: 32'hA3, ordy: 0, exp_ir: 0, exp_ov: 1, exp_d: 32'hA10};
    stall_tbl[4] = '{v: 1, d: 32'hA3, ordy: 0, exp_ir: 0, exp_ov: 1, exp_d: 32'hA10};
    stall_tbl[5] = '{v: 1, d: 32'hA3, ordy: 1, exp_ir: 1, exp_ov: 1, exp_d: 32'hA20};
    stall_tbl[6] = '{v: 1, d: 32'hA4, ordy: 1, exp_ir: 1, exp_ov: 1, exp_d: 32'hA30};
    stall_tbl[7] = '{v: 0, d: 32'h0,  ordy: 1, exp_ir: 1, exp_ov: 1, exp_d: 32'hA40};
    stall_tbl[8] = '{v: 0, d: 32'h0,  ordy: 1, exp_ir: 1, exp_ov: 0, exp_d: 32'h0};
    for (int c = 0; c < 9; c++) begin
      drive(stall_tbl[c].v, stall_tbl[c].d, 5'd4, 3'b000, stall_tbl[c].ordy);
      #1;
      chk_bit($sformatf("stall in_ready c%0d", c), in_ready, stall_tbl[c].exp_ir);
      tick();
      chk_bit($sformatf("stall out_valid c%0d", c), out_valid, stall_tbl[c].exp_ov);
      if (stall_tbl[c].exp_ov) begin
        chk($sformatf("stall out_data c%0d", c), out_data, stall_tbl[c].exp_d);
      end
    end

    // Reset with two requests in flight.
    drive(1'b1, 32'h0000_0001, 5'd1, 3'b000, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0003, 5'd1, 3'b000, 1'b1);
    tick();
    chk_bit("inflight out_valid", out_valid, 1'b1);
    chk("inflight out_data", out_data, 32'h0000_0002);
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_bit("midreset out_valid", out_valid, 1'b0);
    chk("midreset out_data", out_data, 32'h0);
    chk_bit("midreset in_ready", in_ready, 1'b1);
    tick();
    rstn = 1'b1;
    drive(1'b1, 32'h0000_0001, 5'd1, 3'b100, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_bit("no stale result", out_valid, 1'b0);
    tick();
    chk_bit("post-reset result valid", out_valid, 1'b1);
    chk("post-reset result data", out_data, 32'h8000_0000);
    tick();
    chk_bit("post-reset drained", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
